// File: rtl/ibex_fpga_mem_pkg.sv
// Shared types and configuration for the FPGA Ibex memory-port arbiter.
// The package types are sized from the harness configuration below; the top's parameters default to it.
package ibex_fpga_mem_pkg;

    localparam int unsigned NumChCfg  = 2;
    localparam int unsigned AddrWCfg  = 15;
    localparam int unsigned DataWCfg  = 32;
    localparam int unsigned MaxOutCfg = 4;
    localparam int unsigned ChIdxW    = (NumChCfg > 1) ? $clog2(NumChCfg) : 1;

    typedef logic [ChIdxW-1:0] ch_idx_t;

    typedef struct packed {
        logic [AddrWCfg-1:0] addr;
        logic [DataWCfg-1:0] wdata;
        logic [DataWCfg-1:0] strb;
        logic                we;
    } mem_req_t;

    // Round-robin successor of channel cur among n channels.
    function automatic ch_idx_t rr_next(ch_idx_t cur, int unsigned n);
        int unsigned nxt;
        nxt = 32'(cur) + 32'd1;
        if (nxt >= n) nxt = 0;
        return ch_idx_t'(nxt);
    endfunction

endpackage

// File: rtl/ibex_fpga_tag_fifo.sv
// Synchronous FIFO of granted channel IDs; responses come back in grant order.
module ibex_fpga_tag_fifo
    import ibex_fpga_mem_pkg::*;
#(
    parameter int unsigned Depth = MaxOutCfg
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    push_i,
    input  logic    pop_i,
    input  ch_idx_t data_i,
    output logic    full_o,
    output logic    empty_o,
    output ch_idx_t head_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] FullCnt = Depth[PtrW:0];

    ch_idx_t [Depth-1:0] mem_q, mem_d;
    logic [PtrW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PtrW:0]       cnt_q, cnt_d;
    logic                do_push, do_pop;

    assign full_o  = (cnt_q == FullCnt);
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            mem_d[wptr_q] = data_i;
            wptr_d        = wptr_q + PtrW'(1);
        end
        if (do_pop) rptr_d = rptr_q + PtrW'(1);
        cnt_d = cnt_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/ibex_fpga_mem_arbiter.sv
// N-channel round-robin arbiter merging Ibex req/gnt ports onto one memory port,
// with in-order response routing via a tag FIFO and a sticky spurious-response flag.
module ibex_fpga_mem_arbiter
    import ibex_fpga_mem_pkg::*;
#(
    parameter int unsigned NumCh          = NumChCfg,
    parameter int unsigned AddrW          = AddrWCfg,
    parameter int unsigned DataW          = DataWCfg,
    parameter int unsigned MaxOutstanding = MaxOutCfg
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumCh-1:0]            up_req_i,
    output logic [NumCh-1:0]            up_gnt_o,
    input  logic [NumCh-1:0][AddrW-1:0] up_addr_i,
    input  logic [NumCh-1:0][DataW-1:0] up_wdata_i,
    input  logic [NumCh-1:0][DataW-1:0] up_strb_i,
    input  logic [NumCh-1:0]            up_we_i,
    output logic [NumCh-1:0]            up_rvalid_o,
    output logic [NumCh-1:0][DataW-1:0] up_rdata_o,
    output logic                        mem_req_o,
    input  logic                        mem_gnt_i,
    output logic [AddrW-1:0]            mem_addr_o,
    output logic [DataW-1:0]            mem_wdata_o,
    output logic [DataW-1:0]            mem_strb_o,
    output logic                        mem_we_o,
    input  logic                        mem_rvalid_i,
    input  logic [DataW-1:0]            mem_rdata_i,
    output logic                        err_o
);

    ch_idx_t  rr_q, rr_d, winner, head;
    mem_req_t win_req;
    logic     any_req, grant, pop, full, empty;
    logic     err_q, err_d;

    // First requester at or after the rr pointer, wrapping modulo NumCh.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        any_req = 1'b0;
        winner  = rr_q;
        for (int unsigned k = 0; k < NumCh; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= NumCh) idx = idx - NumCh;
            if (!any_req && up_req_i[ch_idx_t'(idx)]) begin
                any_req = 1'b1;
                winner  = ch_idx_t'(idx);
            end
        end
    end

    always_comb begin
        win_req.addr  = up_addr_i[winner];
        win_req.wdata = up_wdata_i[winner];
        win_req.strb  = up_strb_i[winner];
        win_req.we    = up_we_i[winner];
    end

    assign mem_addr_o  = win_req.addr;
    assign mem_wdata_o = win_req.wdata;
    assign mem_strb_o  = win_req.strb;
    assign mem_we_o    = win_req.we;

    // Full blocks requests outright, so a same-cycle pop never opens a push (no rvalid->gnt path).
    assign mem_req_o = rst_ni & any_req & ~full;
    assign grant     = mem_req_o & mem_gnt_i;
    assign pop       = rst_ni & mem_rvalid_i & ~empty;

    always_comb begin
        for (int unsigned c = 0; c < NumCh; c++) begin
            up_gnt_o[c]    = grant & (winner == ch_idx_t'(c));
            up_rvalid_o[c] = pop & (head == ch_idx_t'(c));
            up_rdata_o[c]  = mem_rdata_i;
        end
    end

    always_comb begin
        rr_d  = grant ? rr_next(winner, NumCh) : rr_q;
        err_d = err_q | (mem_rvalid_i & empty);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            rr_q  <= rr_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

    ibex_fpga_tag_fifo #(
        .Depth(MaxOutstanding)
    ) u_tag_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (grant),
        .pop_i  (pop),
        .data_i (winner),
        .full_o (full),
        .empty_o(empty),
        .head_o (head)
    );

endmodule

// File: tb/tb_ibex_fpga_mem_arbiter.sv
// Directed scenarios plus randomized traffic checked against a queue-based reference model.
module tb_ibex_fpga_mem_arbiter;

    localparam int N  = 2;
    localparam int AW = 15;
    localparam int DW = 32;
    localparam int MO = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         up_req, up_gnt, up_we, up_rvalid;
    logic [N-1:0][AW-1:0] up_addr;
    logic [N-1:0][DW-1:0] up_wdata, up_strb, up_rdata;
    logic                 mem_req, mem_gnt, mem_we, mem_rvalid, err;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata, mem_strb, mem_rdata;

    always #5 clk = ~clk;

    ibex_fpga_mem_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .up_req_i(up_req), .up_gnt_o(up_gnt), .up_addr_i(up_addr),
        .up_wdata_i(up_wdata), .up_strb_i(up_strb), .up_we_i(up_we),
        .up_rvalid_o(up_rvalid), .up_rdata_o(up_rdata),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_strb_o(mem_strb), .mem_we_o(mem_we),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .err_o(err)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: queue of granted channel IDs, rr pointer, sticky error.
    int q[$];
    int rr    = 0;
    bit err_m = 1'b0;

    int                   last_win;
    logic [N-1:0]         snap_gnt, snap_rv;
    logic                 snap_req, snap_err;
    logic [N-1:0][DW-1:0] snap_rdata;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs are set just after a negedge; this checks outputs, then crosses one posedge.
    task automatic cycle();
        int           w;
        bit           ereq, g, p;
        logic [N-1:0] egnt, erv;
        #1;
        w = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (rr + k) % N;
            if (w < 0 && up_req[i]) w = i;
        end
        ereq = rst_n && (w >= 0) && (q.size() < MO);
        g    = ereq && mem_gnt;
        p    = rst_n && mem_rvalid && (q.size() > 0);
        egnt = '0;
        erv  = '0;
        if (g) egnt[w] = 1'b1;
        if (p) erv[q[0]] = 1'b1;
        chk("mem_req", 64'(mem_req), 64'(ereq));
        chk("up_gnt", 64'(up_gnt), 64'(egnt));
        chk("up_rvalid", 64'(up_rvalid), 64'(erv));
        chk("err", 64'(err), 64'(err_m));
        if (ereq) begin
            chk("mem_addr", 64'(mem_addr), 64'(up_addr[w]));
            chk("mem_wdata", 64'(mem_wdata), 64'(up_wdata[w]));
            chk("mem_strb", 64'(mem_strb), 64'(up_strb[w]));
            chk("mem_we", 64'(mem_we), 64'(up_we[w]));
        end
        if (p) chk("up_rdata", 64'(up_rdata[q[0]]), 64'(mem_rdata));
        snap_gnt   = up_gnt;
        snap_rv    = up_rvalid;
        snap_req   = mem_req;
        snap_err   = err;
        snap_rdata = up_rdata;
        last_win   = g ? w : -1;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            rr    = 0;
            err_m = 1'b0;
        end else begin
            if (mem_rvalid && q.size() == 0) err_m = 1'b1;
            if (p) void'(q.pop_front());
            if (g) begin
                q.push_back(w);
                rr = (w + 1) % N;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        up_req     = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    logic [N-1:0] fair_exp [4];

    initial begin
        rst_n = 1'b0;
        up_addr = '0; up_wdata = '0; up_strb = '0; up_we = '0;
        mem_rdata = '0;
        idle_inputs();
        @(negedge clk);
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("reset_err", 64'(snap_err), 64'd0);
        chk("reset_req", 64'(snap_req), 64'd0);

        // Single read on ch1, response two cycles after grant.
        up_req = 2'b10; up_addr[1] = 15'h10; mem_gnt = 1'b1;
        cycle();
        chk("single_gnt", 64'(snap_gnt), 64'(2'b10));
        idle_inputs();
        cycle();
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        cycle();
        chk("single_rv", 64'(snap_rv), 64'(2'b10));
        chk("single_rdata", 64'(snap_rdata[1]), 64'hDEADBEEF);
        idle_inputs();
        cycle();
        chk("single_err", 64'(snap_err), 64'd0);

        // Fairness from reset.
        do_reset();
        fair_exp[0] = 2'b01; fair_exp[1] = 2'b10; fair_exp[2] = 2'b01; fair_exp[3] = 2'b10;
        for (int i = 0; i < 4; i++) begin
            up_req = 2'b11; mem_gnt = 1'b1; mem_rvalid = (i > 0);
            cycle();
            chk($sformatf("fair_gnt%0d", i), 64'(snap_gnt), 64'(fair_exp[i]));
        end
        idle_inputs(); mem_rvalid = 1'b1;
        cycle();

        // Full FIFO stalls; a pop does not enable a same-cycle grant.
        do_reset();
        up_req = 2'b01; mem_gnt = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        cycle();
        chk("full_req", 64'(snap_req), 64'd0);
        mem_rvalid = 1'b1;
        cycle();
        chk("full_pop_req", 64'(snap_req), 64'd0);
        chk("full_pop_rv", 64'(snap_rv), 64'(2'b01));
        mem_rvalid = 1'b0;
        cycle();
        chk("full_regrant", 64'(snap_gnt), 64'(2'b01));
        idle_inputs(); mem_rvalid = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        // Ordering: ch1, ch0, ch1 then three responses.
        do_reset();
        mem_gnt = 1'b1;
        up_req = 2'b10; cycle();
        up_req = 2'b01; cycle();
        up_req = 2'b10; cycle();
        idle_inputs(); mem_rvalid = 1'b1;
        mem_rdata = 32'hAAAA0001; cycle();
        chk("ord_rv0", 64'(snap_rv), 64'(2'b10));
        chk("ord_d0", 64'(snap_rdata[1]), 64'hAAAA0001);
        mem_rdata = 32'hBBBB0002; cycle();
        chk("ord_rv1", 64'(snap_rv), 64'(2'b01));
        chk("ord_d1", 64'(snap_rdata[0]), 64'hBBBB0002);
        mem_rdata = 32'hCCCC0003; cycle();
        chk("ord_rv2", 64'(snap_rv), 64'(2'b10));

        // Spurious response with empty FIFO.
        cycle();
        chk("spur_rv", 64'(snap_rv), 64'd0);
        idle_inputs();
        for (int i = 0; i < 3; i++) cycle();
        chk("spur_err_sticky", 64'(snap_err), 64'd1);

        // Reset with two outstanding.
        up_req = 2'b11; mem_gnt = 1'b1;
        cycle(); cycle();
        rst_n = 1'b0;
        cycle();
        chk("mid_rst_req", 64'(snap_req), 64'd0);
        chk("mid_rst_gnt", 64'(snap_gnt), 64'd0);
        rst_n = 1'b1; idle_inputs();
        cycle();
        chk("mid_rst_err", 64'(snap_err), 64'd0);
        up_req = 2'b11; mem_gnt = 1'b1;
        cycle();
        chk("mid_rst_rr0", 64'(snap_gnt), 64'(2'b01));
        do_reset();

        // Randomized traffic; upstream holds req/payload until granted.
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < N; c++) begin
                if (!up_req[c] || last_win == c) begin
                    up_req[c]   = ($urandom_range(0, 2) != 0);
                    up_addr[c]  = AW'($urandom);
                    up_wdata[c] = $urandom;
                    up_strb[c]  = $urandom;
                    up_we[c]    = $urandom_range(0, 1);
                end
            end
            mem_gnt    = ($urandom_range(0, 9) < 7);
            mem_rvalid = (q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 49) == 0);
            mem_rdata  = $urandom;
            rst_n      = ($urandom_range(0, 99) != 0);
            cycle();
            rst_n = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
